raster_plot_scanner: RTL and testbench
======================================

Name: raster_plot_scanner

Overview:
- Sequential successor to the combinational matrix-to-plotter path: walks a stored frame in raster order and emits one (x, y, colour) triple per pixel to the VGA plotter interface.
- Reads pixels from an external synchronous frame memory, one read at a time.
- Adds start/done control, backpressure via valid/ready, and parametrised frame size and colour depth.
- Sits between the frame memory and the VGA adapter's plot port.

Parameters:
- HORIZONTAL, 640, pixels per row (>=2)
- VERTICAL, 480, rows per frame (>=2)
- COLOUR_W, 3, bits per pixel
- X_W, $clog2(HORIZONTAL), x coordinate width
- Y_W, $clog2(VERTICAL), y coordinate width
- ADDR_W, $clog2(HORIZONTAL*VERTICAL), frame memory address width

Ports:
- Clock  input  1  single system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a frame scan when idle
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last pixel handshake
- rd_addr  output  ADDR_W  frame memory read address = y*HORIZONTAL + x
- rd_en  output  1  read strobe; rd_data valid exactly 1 cycle later
- rd_data  input  COLOUR_W  pixel from memory
- plot_valid  output  1  x/y/colour hold a pixel
- plot_ready  input  1  plotter accepts the pixel
- x  output  X_W  column of current pixel
- y  output  Y_W  row of current pixel
- colour  output  COLOUR_W  colour of current pixel

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, rd_en=0, plot_valid=0; x, y, colour, rd_addr = 0.
- FSM states: IDLE, FETCH, WAIT, EMIT, FIN.
- IDLE: done=0. When start=1, clear the x/y counters and the address counter, then go to FETCH.
- FETCH: rd_en=1 for one cycle with rd_addr equal to the current address. Go to WAIT.
- WAIT: register rd_data into colour. Set plot_valid=1 in the next cycle. Go to EMIT.
- EMIT: plot_valid=1. x, y and colour stay stable until plot_valid && plot_ready.
- On a handshake in EMIT:
  - plot_valid drops in the next cycle.
  - If x == HORIZONTAL-1 and y == VERTICAL-1, go to FIN.
  - Otherwise advance and go to FETCH.
- Advance rule: x increments. When x == HORIZONTAL-1, x wraps to 0 and y increments.
- Address counter: increments by 1 per pixel, with no multiplier. rd_addr must always equal y*HORIZONTAL + x.
- FIN: done=1 for exactly one cycle. Go to IDLE.
- Timing and throughput:
  - 3 cycles per pixel minimum (FETCH, WAIT, EMIT with plot_ready=1).
  - Full frame with ready tied high: 3*HORIZONTAL*VERTICAL + 2 cycles from the start pulse to the done pulse.
- start while busy: ignored, no restart.
- start in the same cycle as FIN: ignored. A new start is accepted in IDLE.
- plot_ready high outside EMIT: no effect.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values. No done pulse is emitted.
- Only one memory read is outstanding at a time. rd_en is never asserted in WAIT, EMIT or FIN.
- Counters never exceed HORIZONTAL-1 and VERTICAL-1. There is no wrap past the final pixel.

Optional Feature:
- Macro: SKIP_ZERO_COLOUR_EN
- Defined: in WAIT, if rd_data == 0, the pixel is not emitted. The FSM advances as if handshaken and goes to FETCH, or to FIN if it was the last pixel. plot_valid stays 0 for that pixel. This enables sparse redraws over a cleared screen.
- Not defined: every pixel is emitted regardless of colour.

Test Plan:
1. HORIZONTAL=4, VERTICAL=3; memory[i]=i%8; start pulse; plot_ready=1 -> 12 triples emitted in order (0,0,0),(1,0,1),(2,0,2),(3,0,3),(0,1,4)...(3,2,3). rd_addr runs 0..11. done pulses once at cycle 38 after start. busy=0 afterwards.
2. Same frame; plot_ready toggles 1,0,0,1 repeatedly -> x, y and colour stay stable while plot_valid=1 and ready=0. No pixel is duplicated or skipped. Total triples = 12.
3. Second start pulse asserted at pixel 5 while busy -> ignored. Still exactly 12 triples and one done pulse.
4. Reset asserted asynchronously mid-EMIT at pixel 7 -> plot_valid, busy, x and y go to 0 immediately with no done. A fresh start rescans from (0,0).
5. SKIP_ZERO_COLOUR_EN defined; memory[i]=(i%3==0)?0:5 -> only the 8 pixels with i%3!=0 are emitted, with the correct x/y (first is (1,0,5)). done still pulses once.
6. Frame whose last pixel is (3,2) with plot_ready held 0 for 10 cycles in the final EMIT -> done is not asserted until the cycle after the handshake.

Source files
------------

// File: rtl/raster_plot_scanner.sv
// ============================================================================
// raster_plot_scanner: walks a frame memory in raster order and streams one
// (x, y, colour) triple per pixel to a valid/ready plotter port.
// Optional build macro: SKIP_ZERO_COLOUR_EN (suppresses zero-colour pixels).
// Revision: 1.0
// ============================================================================
`default_nettype none

module raster_plot_scanner #(
  parameter int HORIZONTAL = 640,
  parameter int VERTICAL   = 480,
  parameter int COLOUR_W   = 3,
  parameter int X_W        = $clog2(HORIZONTAL),
  parameter int Y_W        = $clog2(VERTICAL),
  parameter int ADDR_W     = $clog2(HORIZONTAL*VERTICAL)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  output logic                rd_en_o,
  input  logic [COLOUR_W-1:0] rd_data_i,
  output logic                plot_valid_o,
  input  logic                plot_ready_i,
  output logic [X_W-1:0]      x_o,
  output logic [Y_W-1:0]      y_o,
  output logic [COLOUR_W-1:0] colour_o
);

  localparam logic [X_W-1:0] X_LAST = X_W'(HORIZONTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(VERTICAL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  plot_valid_q, plot_valid_d;
  logic                  done_q, done_d;
  logic                  advance;
  logic                  last_pixel;
  logic                  skip_pixel;

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef SKIP_ZERO_COLOUR_EN
  assign skip_pixel = (rd_data_i == '0);
`else
  assign skip_pixel = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    colour_d     = colour_q;
    plot_valid_d = plot_valid_q;
    done_d       = 1'b0;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        colour_d = rd_data_i;
        if (skip_pixel) begin
          advance = 1'b1;
        end else begin
          plot_valid_d = 1'b1;
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        if (plot_ready_i) begin
          plot_valid_d = 1'b0;
          advance      = 1'b1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The linear address tracks x/y incrementally so no multiplier is needed.
    if (advance) begin
      if (last_pixel) begin
        state_d = S_FIN;
      end else begin
        state_d = S_FETCH;
        addr_d  = addr_q + ADDR_W'(1);
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      colour_q     <= '0;
      plot_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      colour_q     <= colour_d;
      plot_valid_q <= plot_valid_d;
      done_q       <= done_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign rd_en_o      = (state_q == S_FETCH);
  assign rd_addr_o    = addr_q;
  assign plot_valid_o = plot_valid_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign colour_o     = colour_q;

endmodule

`default_nettype wire

// File: tb/tb_raster_plot_scanner.sv
// ============================================================================
// tb_raster_plot_scanner: randomized self-checking bench for raster_plot_scanner
// on a 4x3 frame against a pixel-list reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_raster_plot_scanner;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int N  = H * V;
  localparam int CW = 3;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int AW = 4;

  typedef struct { int x; int y; int c; } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [CW-1:0] rd_data = '0;
  logic          busy, done, rd_en, pvalid;
  logic [AW-1:0] rd_addr;
  logic [XW-1:0] xo;
  logic [YW-1:0] yo;
  logic [CW-1:0] colour;

  logic [CW-1:0] mem [N];
  pix_t exp_pix[$];
  pix_t obs[$];
  int   rd_q[$];
  int   exp_cycles;
  int   done_cnt, done_cycle, last_hs, stab_err;
  bit   reset_hit;
  int   checks = 0;
  int   failures = 0;

  raster_plot_scanner #(
    .HORIZONTAL(H), .VERTICAL(V), .COLOUR_W(CW),
    .X_W(XW), .Y_W(YW), .ADDR_W(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done),
    .rd_addr_o(rd_addr), .rd_en_o(rd_en), .rd_data_i(rd_data),
    .plot_valid_o(pvalid), .plot_ready_i(ready),
    .x_o(xo), .y_o(yo), .colour_o(colour)
  );

  always #5 clk = ~clk;

  // Synchronous frame memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en && int'(rd_addr) < N) rd_data <= mem[int'(rd_addr)];
  end

  task automatic build_expected();
    bit skip;
    exp_pix.delete();
    exp_cycles = 2;
    for (int i = 0; i < N; i++) begin
      skip = 1'b0;
`ifdef SKIP_ZERO_COLOUR_EN
      skip = (mem[i] == '0);
`endif
      if (skip) exp_cycles += 2;
      else begin
        exp_cycles += 3;
        exp_pix.push_back('{i % H, i / H, int'(mem[i])});
      end
    end
  endtask

  function automatic int first_pixel_mismatch();
    int n;
    n = (obs.size() < exp_pix.size()) ? obs.size() : exp_pix.size();
    for (int i = 0; i < n; i++)
      if (obs[i].x != exp_pix[i].x || obs[i].y != exp_pix[i].y || obs[i].c != exp_pix[i].c)
        return i;
    if (obs.size() != exp_pix.size()) return n;
    return -1;
  endfunction

  function automatic int first_read_mismatch();
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] != i) return i;
    if (rd_q.size() != N) return rd_q.size();
    return -1;
  endfunction

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready, 3 stall final pixel 10 cycles
  task automatic run_scan(input int mode, input int restart_at, input int reset_at);
    int hold;
    bit restarted, pv, pr;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [CW-1:0] pc;
    obs.delete(); rd_q.delete();
    done_cnt = 0; done_cycle = -1; last_hs = -1; stab_err = 0; reset_hit = 0;
    hold = 0; restarted = 0; pv = 0; pr = 0; px = '0; py = '0; pc = '0;
    @(posedge clk); #1 start = 1'b1; ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (pv && !pr && (!pvalid || xo !== px || yo !== py || colour !== pc)) stab_err++;
      if (reset_at >= 0 && pvalid && obs.size() == reset_at) begin
        ready = 1'b0;
        reset_hit = 1'b1;
        return;
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = (k % 4 == 0) || (k % 4 == 3);
        2: ready = 1'($urandom_range(0, 1));
        default: begin
          if (pvalid && obs.size() == exp_pix.size() - 1 && hold < 10) begin
            ready = 1'b0;
            hold++;
          end else ready = 1'b1;
        end
      endcase
      if (restart_at >= 0 && !restarted && obs.size() == restart_at && busy) begin
        start = 1'b1;
        restarted = 1'b1;
      end else start = 1'b0;
      if (pvalid && ready) begin
        obs.push_back('{int'(xo), int'(yo), int'(colour)});
        last_hs = k;
      end
      pv = pvalid; pr = ready; px = xo; py = yo; pc = colour;
      if (done_cycle >= 0 && k >= done_cycle + 4) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = CW'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, pvalid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/rd_en/valid=%b expected 0000", {busy, done, rd_en, pvalid});
    end
    checks++;
    if (xo !== '0 || yo !== '0 || colour !== '0 || rd_addr !== '0) begin
      failures++;
      $display("FAIL reset_data: x=%0d y=%0d colour=%0d addr=%0d expected all 0", xo, yo, colour, rd_addr);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_ready_high();
    int m;
    fill_random();
    build_expected();
    run_scan(0, -1, -1);
    m = first_pixel_mismatch();
    checks++;
    if (m !== -1) begin
      failures++;
      $display("FAIL ready_high_pixels: first bad index %0d (got %0d pixels, expected %0d)", m, obs.size(), exp_pix.size());
    end
    m = first_read_mismatch();
    checks++;
    if (m !== -1) begin
      failures++;
      $display("FAIL ready_high_rdaddr: first bad read %0d of %0d, expected addresses 0..%0d", m, rd_q.size(), N - 1);
    end
    checks++;
    if (done_cnt !== 1 || done_cycle !== exp_cycles) begin
      failures++;
      $display("FAIL ready_high_done: count=%0d cycle=%0d expected count=1 cycle=%0d", done_cnt, done_cycle, exp_cycles);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_high_busy_after: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int m;
    for (int mode = 1; mode <= 2; mode++) begin
      fill_random();
      build_expected();
      run_scan(mode, -1, -1);
      m = first_pixel_mismatch();
      checks++;
      if (m !== -1) begin
        failures++;
        $display("FAIL backpressure_pixels mode %0d: first bad index %0d (got %0d, expected %0d)", mode, m, obs.size(), exp_pix.size());
      end
      checks++;
      if (stab_err !== 0) begin
        failures++;
        $display("FAIL backpressure_stable mode %0d: %0d unstable stalled cycles, expected 0", mode, stab_err);
      end
      checks++;
      if (done_cnt !== 1) begin
        failures++;
        $display("FAIL backpressure_done mode %0d: done pulses=%0d expected 1", mode, done_cnt);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int m;
    fill_random();
    build_expected();
    run_scan(0, 5, -1);
    m = first_pixel_mismatch();
    checks++;
    if (m !== -1) begin
      failures++;
      $display("FAIL restart_pixels: first bad index %0d (got %0d, expected %0d)", m, obs.size(), exp_pix.size());
    end
    checks++;
    if (done_cnt !== 1 || done_cycle !== exp_cycles) begin
      failures++;
      $display("FAIL restart_done: count=%0d cycle=%0d expected count=1 cycle=%0d", done_cnt, done_cycle, exp_cycles);
    end
  endtask

  task automatic test_reset_mid_scan();
    int m, dseen;
    for (int i = 0; i < N; i++) mem[i] = CW'(1 + (i % 7));
    build_expected();
    run_scan(0, -1, 7);
    checks++;
    if (reset_hit !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reach: pixel 7 EMIT reached=%b expected 1", reset_hit);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pvalid, busy, done, rd_en} !== 4'b0000 || xo !== '0 || yo !== '0) begin
      failures++;
      $display("FAIL midreset_async: valid/busy/done/rd_en=%b x=%0d y=%0d expected 0000 0 0", {pvalid, busy, done, rd_en}, xo, yo);
    end
    dseen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    checks++;
    if (dseen !== 0) begin
      failures++;
      $display("FAIL midreset_no_done: done pulses=%0d expected 0", dseen);
    end
    run_scan(0, -1, -1);
    m = first_pixel_mismatch();
    checks++;
    if (m !== -1) begin
      failures++;
      $display("FAIL midreset_rescan: first bad index %0d (got %0d, expected %0d)", m, obs.size(), exp_pix.size());
    end
  endtask

  task automatic test_sparse_pattern();
    int m;
    for (int i = 0; i < N; i++) mem[i] = (i % 3 == 0) ? CW'(0) : CW'(5);
    build_expected();
    run_scan(0, -1, -1);
    m = first_pixel_mismatch();
    checks++;
    if (m !== -1) begin
      failures++;
      $display("FAIL sparse_pixels: first bad index %0d (got %0d, expected %0d)", m, obs.size(), exp_pix.size());
    end
    checks++;
    if (done_cnt !== 1 || done_cycle !== exp_cycles) begin
      failures++;
      $display("FAIL sparse_done: count=%0d cycle=%0d expected count=1 cycle=%0d", done_cnt, done_cycle, exp_cycles);
    end
  endtask

  task automatic test_final_stall();
    int m;
    fill_random();
    mem[N-1] = CW'(6);
    build_expected();
    run_scan(3, -1, -1);
    m = first_pixel_mismatch();
    checks++;
    if (m !== -1) begin
      failures++;
      $display("FAIL final_stall_pixels: first bad index %0d (got %0d, expected %0d)", m, obs.size(), exp_pix.size());
    end
    checks++;
    if (done_cnt !== 1 || done_cycle !== last_hs + 2 || done_cycle !== exp_cycles + 10) begin
      failures++;
      $display("FAIL final_stall_done: count=%0d cycle=%0d expected count=1 cycle=%0d (handshake at %0d)", done_cnt, done_cycle, exp_cycles + 10, last_hs);
    end
  endtask

  initial begin
    test_reset();
    test_ready_high();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_scan();
    test_sparse_pattern();
    test_final_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
